// File: rtl/ema_meas_sequencer.sv
// EMA measurement shot sequencer: ON_32 charge, P/N excitation burst, capture launch,
// then hold-off until the FSMC reader has drained the capture buffer.
module ema_meas_sequencer #(
  parameter int CHARGE_CYC  = 6400000,
  parameter int PULSE_W     = 10,
  parameter int PULSE_GAP   = 3,
  parameter int NUM_PULSES  = 2,
  parameter int TIMEOUT_CYC = 16777215
) (
  input  logic       clk_80mhz,
  input  logic       rst,
  input  logic       start_in,
  input  logic       abort,
  input  logic       cap_done,
  input  logic       rd_done,
  output logic       ema_p_n,
  output logic       ema_n_n,
  output logic       on_32_n,
  output logic       cap_start,
  output logic       busy,
  output logic       data_ready,
  output logic       timeout_err,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHARGE  = 3'd1,
    PULSE_P = 3'd2,
    PULSE_N = 3'd3,
    GAP     = 3'd4,
    CAPTURE = 3'd5,
    READOUT = 3'd6
  } state_t;

  localparam logic [23:0] CHARGE_LAST  = 24'(CHARGE_CYC - 1);
  localparam logic [23:0] PULSE_LAST   = 24'(PULSE_W - 1);
  localparam logic [23:0] GAP_LAST     = 24'((PULSE_GAP > 0) ? PULSE_GAP - 1 : 0);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  PAIR_LAST    = 4'(NUM_PULSES - 1);

  state_t      state_reg, state_next;
  logic [23:0] phase_reg, phase_next;
  logic [3:0]  pair_reg, pair_next;
  logic        sync1_reg, sync2_reg, prev_reg;
  logic        start_edge;
  logic        timeout_err_next;
  logic        ema_p_n_next, ema_n_n_next, on_32_n_next;
  logic        cap_start_next, busy_next, data_ready_next;

  assign start_edge = sync2_reg & ~prev_reg;
  assign state_o    = state_reg;

  always_comb begin
    state_next       = state_reg;
    pair_next        = pair_reg;
    timeout_err_next = timeout_err;
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next       = CHARGE;
          pair_next        = 4'd0;
          timeout_err_next = 1'b0;
        end
      end
      CHARGE:  if (phase_reg == CHARGE_LAST) state_next = PULSE_P;
      PULSE_P: if (phase_reg == PULSE_LAST) state_next = PULSE_N;
      PULSE_N: begin
        if (phase_reg == PULSE_LAST) begin
          if (pair_reg == PAIR_LAST) begin
            state_next = CAPTURE;
          end else begin
            pair_next = pair_reg + 4'd1;
            if (PULSE_GAP == 0) state_next = PULSE_P;
            else                state_next = GAP;
          end
        end
      end
      GAP:     if (phase_reg == GAP_LAST) state_next = PULSE_P;
      // The awaited input takes precedence over an expiring timeout.
      CAPTURE: begin
        if (cap_done) begin
          state_next = READOUT;
        end else if (phase_reg == TIMEOUT_LAST) begin
          state_next       = IDLE;
          timeout_err_next = 1'b1;
        end
      end
      READOUT: begin
        if (rd_done) begin
          state_next = IDLE;
        end else if (phase_reg == TIMEOUT_LAST) begin
          state_next       = IDLE;
          timeout_err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort) begin
      state_next       = IDLE;
      pair_next        = pair_reg;
      timeout_err_next = timeout_err;
    end

    // Phase counter restarts on every state change; it doubles as the timeout counter.
    if (state_next != state_reg || state_next == IDLE) phase_next = 24'd0;
    else                                               phase_next = phase_reg + 24'd1;

    on_32_n_next    = !(state_next == CHARGE || state_next == PULSE_P ||
                        state_next == PULSE_N || state_next == GAP);
    ema_p_n_next    = (state_next != PULSE_P);
    ema_n_n_next    = (state_next != PULSE_N);
    cap_start_next  = (state_reg == CHARGE) && (state_next == PULSE_P);
    busy_next       = (state_next != IDLE);
    data_ready_next = (state_next == READOUT);
  end

  always_ff @(posedge clk_80mhz or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      phase_reg   <= 24'd0;
      pair_reg    <= 4'd0;
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      prev_reg    <= 1'b0;
      ema_p_n     <= 1'b1;
      ema_n_n     <= 1'b1;
      on_32_n     <= 1'b1;
      cap_start   <= 1'b0;
      busy        <= 1'b0;
      data_ready  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      pair_reg    <= pair_next;
      sync1_reg   <= start_in;
      sync2_reg   <= sync1_reg;
      prev_reg    <= sync2_reg;
      ema_p_n     <= ema_p_n_next;
      ema_n_n     <= ema_n_n_next;
      on_32_n     <= on_32_n_next;
      cap_start   <= cap_start_next;
      busy        <= busy_next;
      data_ready  <= data_ready_next;
      timeout_err <= timeout_err_next;
    end
  end

endmodule

// File: tb/tb_ema_meas_sequencer.sv
// Directed bench for ema_meas_sequencer: full shots, ignored re-triggers, timeout, abort,
// asynchronous reset and a single-pair/no-gap variant, against hand-computed timelines.
module tb_ema_meas_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic start_in = 1'b0;
  logic abort = 1'b0;
  logic cap_done = 1'b0;
  logic rd_done = 1'b0;

  logic       ema_p_n1, ema_n_n1, on_32_n1, cap_start1, busy1, data_ready1, timeout_err1;
  logic [2:0] state_o1;
  logic       ema_p_n2, ema_n_n2, on_32_n2, cap_start2, busy2, data_ready2, timeout_err2;
  logic [2:0] state_o2;
  logic [9:0] obs1, obs2;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] RST_VEC = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  ema_meas_sequencer #(
    .CHARGE_CYC(20), .PULSE_W(10), .PULSE_GAP(3), .NUM_PULSES(2), .TIMEOUT_CYC(100)
  ) dut (
    .clk_80mhz(clk), .rst(rst), .start_in(start_in), .abort(abort),
    .cap_done(cap_done), .rd_done(rd_done),
    .ema_p_n(ema_p_n1), .ema_n_n(ema_n_n1), .on_32_n(on_32_n1), .cap_start(cap_start1),
    .busy(busy1), .data_ready(data_ready1), .timeout_err(timeout_err1), .state_o(state_o1)
  );

  ema_meas_sequencer #(
    .CHARGE_CYC(20), .PULSE_W(10), .PULSE_GAP(0), .NUM_PULSES(1), .TIMEOUT_CYC(100)
  ) dut2 (
    .clk_80mhz(clk), .rst(rst2), .start_in(start_in), .abort(abort),
    .cap_done(cap_done), .rd_done(rd_done),
    .ema_p_n(ema_p_n2), .ema_n_n(ema_n_n2), .on_32_n(on_32_n2), .cap_start(cap_start2),
    .busy(busy2), .data_ready(data_ready2), .timeout_err(timeout_err2), .state_o(state_o2)
  );

  // Bit order: state[2:0], on_32_n, ema_p_n, ema_n_n, cap_start, busy, data_ready, timeout_err
  assign obs1 = {state_o1, on_32_n1, ema_p_n1, ema_n_n1, cap_start1, busy1, data_ready1, timeout_err1};
  assign obs2 = {state_o2, on_32_n2, ema_p_n2, ema_n_n2, cap_start2, busy2, data_ready2, timeout_err2};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k cycles after the accepted start edge (k=1 is the first CHARGE cycle).
  function automatic logic [9:0] exp_vec(int k, bit short_cfg, int cap_k, int rd_k, int abort_k);
    int   st;
    int   last_n;
    logic terr;
    logic cs;
    terr   = 1'b0;
    last_n = short_cfg ? 40 : 63;
    if (abort_k != 0 && k > abort_k)     st = 0;
    else if (k <= 20)                    st = 1;
    else if (k <= 30)                    st = 2;
    else if (k <= 40)                    st = 3;
    else if (!short_cfg && k <= 43)      st = 4;
    else if (!short_cfg && k <= 53)      st = 2;
    else if (!short_cfg && k <= 63)      st = 3;
    else if (cap_k == 0) begin
      if (k <= last_n + 100) st = 5;
      else begin st = 0; terr = 1'b1; end
    end
    else if (k <= cap_k)                 st = 5;
    else if (k <= rd_k)                  st = 6;
    else                                 st = 0;
    cs = (k == 21) && (st == 2);
    return {3'(st), !(st >= 1 && st <= 4), (st != 2), (st != 3), cs, (st != 0), (st == 6), terr};
  endfunction

  task automatic run_shot(input string name, input bit sel, input bit short_cfg,
                          input int cap_k, input int rd_k, input int abort_k,
                          input int n_cyc, input bit retrig, input bit terr_before);
    logic [9:0] o;
    logic [9:0] e;
    bit         found;
    int         k;
    int         shot_errs;
    shot_errs = errors;
    start_in = 1'b0;
    repeat (4) tick();
    o = sel ? obs2 : obs1;
    e = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, terr_before};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s idle_before_start: got %b expected %b", name, o, e);
    end
    start_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      o = sel ? obs2 : obs1;
      if (o[6] === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s start_response: on_32_n got %b expected 0 within 10 cycles", name, o[6]);
      return;
    end
    for (k = 1; k <= n_cyc; k++) begin
      o = sel ? obs2 : obs1;
      e = exp_vec(k, short_cfg, cap_k, rd_k, abort_k);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle_%0d: got %b expected %b", name, k, o, e);
      end
      cap_done = (k == cap_k);
      rd_done  = (k == rd_k);
      abort    = (k == abort_k);
      if (retrig) start_in = !((k >= 30 && k < 35) || (k >= 100 && k < 120));
      tick();
    end
    cap_done = 1'b0;
    rd_done  = 1'b0;
    abort    = 1'b0;
    start_in = 1'b0;
    $display("shot %-14s cycles %0d errors_in_shot %0d", name, n_cyc, errors - shot_errs);
  endtask

  task automatic test_reset;
    tick();
    checks++;
    if (obs1 !== RST_VEC) begin
      errors++;
      $display("FAIL reset_state_main: got %b expected %b", obs1, RST_VEC);
    end
    checks++;
    if (obs2 !== RST_VEC) begin
      errors++;
      $display("FAIL reset_state_short: got %b expected %b", obs2, RST_VEC);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_shot;
    run_shot("basic", 1'b0, 1'b0, 114, 144, 0, 150, 1'b0, 1'b0);
  endtask

  task automatic test_retrigger;
    run_shot("retrigger", 1'b0, 1'b0, 114, 144, 0, 150, 1'b1, 1'b0);
  endtask

  task automatic test_timeout;
    run_shot("timeout", 1'b0, 1'b0, 0, 0, 0, 170, 1'b0, 1'b0);
    run_shot("after_timeout", 1'b0, 1'b0, 114, 144, 0, 150, 1'b0, 1'b1);
  endtask

  task automatic test_abort;
    run_shot("abort_gap", 1'b0, 1'b0, 0, 0, 42, 50, 1'b0, 1'b0);
    run_shot("after_abort1", 1'b0, 1'b0, 114, 144, 0, 150, 1'b0, 1'b0);
    run_shot("abort_readout", 1'b0, 1'b0, 114, 144, 120, 130, 1'b0, 1'b0);
    run_shot("after_abort2", 1'b0, 1'b0, 114, 144, 0, 150, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset;
    bit found;
    start_in = 1'b0;
    repeat (4) tick();
    start_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (on_32_n1 === 1'b0) found = 1'b1;
    end
    repeat (25) tick();
    checks++;
    if (ema_p_n1 !== 1'b0 || state_o1 !== 3'd2) begin
      errors++;
      $display("FAIL async_reset_precondition: state %0d ema_p_n %b expected state 2 ema_p_n 0",
               state_o1, ema_p_n1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs1 !== RST_VEC) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected %b", obs1, RST_VEC);
    end
    tick();
    rst = 1'b0;
    start_in = 1'b0;
    tick();
    $display("shot %-14s reset mid PULSE_P", "async_reset");
    run_shot("after_reset", 1'b0, 1'b0, 114, 144, 0, 150, 1'b0, 1'b0);
  endtask

  task automatic test_short_config;
    rst2 = 1'b0;
    tick();
    run_shot("short_abort", 1'b1, 1'b1, 60, 0, 60, 70, 1'b0, 1'b0);
    run_shot("short_normal", 1'b1, 1'b1, 60, 70, 0, 80, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_shot();
    test_retrigger();
    test_timeout();
    test_abort();
    test_async_reset();
    test_short_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
